// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and a helper that sizes the iteration counter.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold the iteration count 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit the quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int DWIDTH = 4
) (
  input  logic [DWIDTH:0]   p_in,
  input  logic              bit_in,
  input  logic [DWIDTH-1:0] divisor,
  output logic [DWIDTH:0]   p_out,
  output logic              q_bit
);

  // Between steps the partial remainder is always below the divisor, so
  // its MSB is zero and drops out of the shift.
  logic              unused_p_msb;
  logic [DWIDTH:0]   p_shift;
  logic [DWIDTH:0]   dvs_ext;

  assign unused_p_msb = p_in[DWIDTH];
  assign p_shift      = {p_in[DWIDTH-1:0], bit_in};
  assign dvs_ext      = {1'b0, divisor};

  // Trial subtraction; keep the difference only when it does not underflow.
  always_comb begin
    q_bit = 1'b0;
    p_out = p_shift;
    if (p_shift >= dvs_ext) begin
      q_bit = 1'b1;
      p_out = p_shift - dvs_ext;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: WIDTH-bit dividend by DWIDTH-bit divisor,
// one quotient bit per clock, start/busy/done handshake, divide-by-zero flag.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [DWIDTH-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              div_by_zero
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state_reg, state_next;

  logic [WIDTH-1:0]  s_reg,    s_next;     // dividend shifting out, quotient shifting in
  logic [DWIDTH:0]   p_reg,    p_next;     // partial remainder
  logic [CNT_W-1:0]  cnt_reg,  cnt_next;   // steps still to run
  logic [DWIDTH-1:0] dvs_reg,  dvs_next;   // divisor captured at the accepting edge
  logic [WIDTH-1:0]  quot_reg, quot_next;
  logic [DWIDTH-1:0] rem_reg,  rem_next;
  logic              dbz_reg,  dbz_next;

  logic [DWIDTH:0]   step_p;
  logic              step_q;

  div_step #(
    .DWIDTH(DWIDTH)
  ) u_step (
    .p_in    (p_reg),
    .bit_in  (s_reg[WIDTH-1]),
    .divisor (dvs_reg),
    .p_out   (step_p),
    .q_bit   (step_q)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath update: accept in IDLE/DONE, iterate in RUN.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    p_next     = p_reg;
    cnt_next   = cnt_reg;
    dvs_next   = dvs_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;

    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          if (divisor == '0) begin
            // No iterations: the result is defined directly.
            quot_next  = '1;
            rem_next   = '0;
            dbz_next   = 1'b1;
            state_next = DONE;
          end else begin
            s_next     = dividend;
            p_next     = '0;
            cnt_next   = CNT_LOAD;
            dvs_next   = divisor;
            state_next = RUN;
          end
        end
      end

      RUN: begin
        s_next   = {s_reg[WIDTH-2:0], step_q};
        p_next   = step_p;
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          // Last step: publish the freshly completed quotient/remainder.
          quot_next  = {s_reg[WIDTH-2:0], step_q};
          rem_next   = step_p[DWIDTH-1:0];
          dbz_next   = 1'b0;
          state_next = DONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg    <= '0;
      p_reg    <= '0;
      cnt_reg  <= '0;
      dvs_reg  <= '0;
      quot_reg <= '0;
      rem_reg  <= '0;
      dbz_reg  <= 1'b0;
    end else begin
      s_reg    <= s_next;
      p_reg    <= p_next;
      cnt_reg  <= cnt_next;
      dvs_reg  <= dvs_next;
      quot_reg <= quot_next;
      rem_reg  <= rem_next;
      dbz_reg  <= dbz_next;
    end
  end

  // Handshake flags decode straight from the registered state.
  assign busy        = (state_reg == RUN);
  assign done        = (state_reg == DONE);
  assign quotient    = quot_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: an 8/4 instance for directed cases
// and a 16/8 instance for the divisor sweep.
module tb_seq_divider;

  logic clk;
  logic rst;

  logic       start_a;
  logic [7:0] dividend_a;
  logic [3:0] divisor_a;
  logic       busy_a, done_a, dbz_a;
  logic [7:0] quotient_a;
  logic [3:0] remainder_a;

  logic        start_b;
  logic [15:0] dividend_b;
  logic [7:0]  divisor_b;
  logic        busy_b, done_b, dbz_b;
  logic [15:0] quotient_b;
  logic [7:0]  remainder_b;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          acc;
    int          lat;
    int          bsy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_cnt_a = 0;
  int busy_cnt_b = 0;
  int last_done_b = -1;
  int n_a = 0;
  int n_b = 0;

  seq_divider #(.WIDTH(8), .DWIDTH(4)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start_a),
    .dividend    (dividend_a),
    .divisor     (divisor_a),
    .busy        (busy_a),
    .done        (done_a),
    .quotient    (quotient_a),
    .remainder   (remainder_a),
    .div_by_zero (dbz_a)
  );

  seq_divider #(.WIDTH(16), .DWIDTH(8)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .dividend    (dividend_b),
    .divisor     (divisor_b),
    .busy        (busy_b),
    .done        (done_b),
    .quotient    (quotient_b),
    .remainder   (remainder_b),
    .div_by_zero (dbz_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor for the 8/4 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt_a = 0;
      end else begin
        if (busy_a) busy_cnt_a++;
        if (done_a) begin
          if (q_a.size() == 0) begin
            chk("a_unexpected_done", 64'(done_a), 64'd0);
          end else begin
            e = q_a.pop_front();
            n_a++;
            chk("a_quotient",  64'(quotient_a),  64'(e.q));
            chk("a_remainder", 64'(remainder_a), 64'(e.r));
            chk("a_dbz",       64'(dbz_a),       64'(e.dbz));
            chk("a_latency",   64'(cyc - e.acc + 1), 64'(e.lat));
            chk("a_busy_cycles", 64'(busy_cnt_a), 64'(e.bsy));
            $display("a op%0d: q=%0d r=%0d dbz=%0b latency=%0d busy=%0d",
                     n_a, quotient_a, remainder_a, dbz_a, cyc - e.acc + 1, busy_cnt_a);
          end
          busy_cnt_a = 0;
        end
      end
    end
  end

  // Monitor for the 16/8 instance, including done-to-done spacing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt_b  = 0;
        last_done_b = -1;
      end else begin
        if (busy_b) busy_cnt_b++;
        if (done_b) begin
          if (q_b.size() == 0) begin
            chk("b_unexpected_done", 64'(done_b), 64'd0);
          end else begin
            e = q_b.pop_front();
            n_b++;
            chk("b_quotient",  64'(quotient_b),  64'(e.q));
            chk("b_remainder", 64'(remainder_b), 64'(e.r));
            chk("b_dbz",       64'(dbz_b),       64'(e.dbz));
            chk("b_latency",   64'(cyc - e.acc + 1), 64'(e.lat));
            chk("b_busy_cycles", 64'(busy_cnt_b), 64'(e.bsy));
            if (last_done_b >= 0) chk("b_spacing", 64'(cyc - last_done_b), 64'd17);
            $display("b op%0d: q=%0d r=%0d dbz=%0b latency=%0d",
                     n_b, quotient_b, remainder_b, dbz_b, cyc - e.acc + 1);
          end
          last_done_b = cyc;
          busy_cnt_b  = 0;
        end
      end
    end
  end

  // Present an operation for one edge; caller guarantees IDLE or DONE.
  task automatic issue_a(input logic [7:0] a, input logic [3:0] d,
                         input logic [7:0] eq, input logic [3:0] er, input logic edbz);
    exp_t e;
    start_a    = 1'b1;
    dividend_a = a;
    divisor_a  = d;
    @(posedge clk);
    #1;
    e.q = 16'(eq); e.r = 8'(er); e.dbz = edbz; e.acc = cyc;
    e.lat = (d == 4'd0) ? 1 : 9;
    e.bsy = (d == 4'd0) ? 0 : 8;
    q_a.push_back(e);
    start_a    = 1'b0;
    dividend_a = 8'hA5;
    divisor_a  = 4'h1;
  endtask

  task automatic issue_b(input logic [15:0] a, input logic [7:0] d,
                         input logic [15:0] eq, input logic [7:0] er);
    exp_t e;
    start_b    = 1'b1;
    dividend_b = a;
    divisor_b  = d;
    @(posedge clk);
    #1;
    e.q = eq; e.r = er; e.dbz = 1'b0; e.acc = cyc; e.lat = 17; e.bsy = 16;
    q_b.push_back(e);
    start_b    = 1'b0;
    dividend_b = 16'h5A5A;
    divisor_b  = 8'h03;
  endtask

  task automatic wait_done_a(input int limit);
    int n = 0;
    while (!done_a && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done_a) chk("a_done_timeout", 64'(done_a), 64'd1);
  endtask

  task automatic wait_done_b(input int limit);
    int n = 0;
    while (!done_b && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done_b) chk("b_done_timeout", 64'(done_b), 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_busy"},      64'(busy_a),      64'd0);
    chk({tag, "_done"},      64'(done_a),      64'd0);
    chk({tag, "_quotient"},  64'(quotient_a),  64'd0);
    chk({tag, "_remainder"}, 64'(remainder_a), 64'd0);
    chk({tag, "_dbz"},       64'(dbz_a),       64'd0);
  endtask

  logic [15:0] b_a[5] = '{16'd65535, 16'd65535, 16'd0,   16'd1000, 16'd65534};
  logic [7:0]  b_d[5] = '{8'd1,      8'd255,    8'd255,  8'd3,     8'd255};
  logic [15:0] b_q[5] = '{16'd65535, 16'd257,   16'd0,   16'd333,  16'd256};
  logic [7:0]  b_r[5] = '{8'd0,      8'd0,      8'd0,    8'd1,     8'd254};

  initial begin
    logic [15:0] rnd;
    rst        = 1'b1;
    start_a    = 1'b0;
    dividend_a = '0;
    divisor_a  = '0;
    start_b    = 1'b0;
    dividend_b = '0;
    divisor_b  = '0;

    // Reset state, held and after release.
    @(posedge clk);
    #1;
    chk_zero_a("rst_a");
    chk("rst_b_quotient", 64'(quotient_b), 64'd0);
    chk("rst_b_busy",     64'(busy_b),     64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    chk_zero_a("idle_a");

    // 200/7 from IDLE, then back-to-back ops each started in the DONE cycle.
    issue_a(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    wait_done_a(20);
    issue_a(8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
    wait_done_a(20);
    issue_a(8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
    wait_done_a(20);
    issue_a(8'd100, 4'd0, 8'hFF, 4'd0, 1'b1);
    wait_done_a(20);
    issue_a(8'd17, 4'd5, 8'd3, 4'd2, 1'b0);
    wait_done_a(20);
    issue_a(8'd254, 4'd15, 8'd16, 4'd14, 1'b0);
    wait_done_a(20);
    idle(2);

    // Start pulse while busy must be ignored.
    issue_a(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    idle(2);
    start_a    = 1'b1;
    dividend_a = 8'd9;
    divisor_a  = 4'd3;
    idle(1);
    start_a    = 1'b0;
    wait_done_a(20);
    idle(4);

    // Asynchronous reset mid-run: outputs clear at once, no done follows.
    issue_a(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    idle(3);
    #2;
    rst = 1'b1;
    #1;
    chk_zero_a("abort_a");
    q_a.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(12);
    chk("abort_no_done", 64'(q_a.size()), 64'd0);
    issue_a(8'd17, 4'd4, 8'd4, 4'd1, 1'b0);
    wait_done_a(20);
    idle(2);

    // Wide instance: directed corner cases then a sweep of every divisor.
    for (int i = 0; i < 5; i++) begin
      issue_b(b_a[i], b_d[i], b_q[i], b_r[i]);
      wait_done_b(40);
    end
    for (int d = 1; d <= 255; d++) begin
      rnd = 16'($urandom_range(0, 65535));
      issue_b(rnd, 8'(d), rnd / 16'(d), 8'(rnd % 16'(d)));
      wait_done_b(40);
    end
    idle(4);

    chk("a_pending", 64'(q_a.size()), 64'd0);
    chk("b_pending", 64'(q_b.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
